// File: rtl/cam_tx_pkg.sv
// cam_tx_pkg: shared types and constants for the DVP camera transmitter.
//   cam_state_t : timing FSM state encoding (legacy-compatible localparams)
//   tx_ctl_t    : per-cycle strobes from the timing block to the datapath
//   HBLANK_MIN  : smallest legal line blanking (first-word prefetch needs 2 cycles)
//   LFSR_SEED   : reset value of the data_ok gap generator
package cam_tx_pkg;

  typedef logic [2:0] cam_state_t;

  localparam cam_state_t S_IDLE   = 3'd0;
  localparam cam_state_t S_VSYNC  = 3'd1;
  localparam cam_state_t S_VBP    = 3'd2;
  localparam cam_state_t S_ACTIVE = 3'd3;
  localparam cam_state_t S_HBL    = 3'd4;
  localparam cam_state_t S_VFP    = 3'd5;

  localparam int          HBLANK_MIN = 4;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;

  // href    : line valid
  // fetch   : issue a frame-buffer read this cycle
  // load    : move the next word into the output word register at this edge
  // phase   : sample index within the current word
  typedef struct packed {
    logic       href;
    logic       fetch;
    logic       load;
    logic [1:0] phase;
  } tx_ctl_t;

  // Fibonacci LFSR, taps 16/14/13/11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/cam_tx_timing.sv
// cam_tx_timing: frame/line FSM and counters for cam_tx.
//   clk, rstn            : clock, synchronous active-low reset
//   start_i, continuous_i: frame start pulse, auto-restart enable
//   line_samples_i       : samples per line (bits [1:0] dropped)
//   lines_i              : active lines per frame
//   accept_o             : start accepted this cycle (latch frame config)
//   ctl_o                : href/fetch/load/phase strobes for the datapath
//   vsync_o, dok_o, busy_o, frame_done_o, cfg_err_o : direct outputs
// Optional: CAM_TX_DOK_GAP_EN adds LFSR-driven data_ok gaps during ACTIVE.
module cam_tx_timing
  import cam_tx_pkg::*;
#(
  parameter int W_CNT     = 12,
  parameter int VS_LINES  = 2,
  parameter int VBP_LINES = 2,
  parameter int VFP_LINES = 1,
  parameter int HBLANK    = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start_i,
  input  logic             continuous_i,
  input  logic [W_CNT-1:0] line_samples_i,
  input  logic [W_CNT-1:0] lines_i,
  output logic             accept_o,
  output tx_ctl_t          ctl_o,
  output logic             vsync_o,
  output logic             dok_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             cfg_err_o
);
  // Blanking shorter than the minimum would leave no room for the line's
  // first-word read, so it is clamped up.
  localparam int HB  = (HBLANK < HBLANK_MIN) ? HBLANK_MIN : HBLANK;
  localparam int W_T = ((W_CNT > $clog2(HB + 1)) ? W_CNT : $clog2(HB + 1)) + 1;
  localparam int W_W = W_CNT - 2;

  cam_state_t       state;
  logic [W_T-1:0]   cyc, t_len;
  logic [W_CNT-1:0] lcnt, scnt, ls_q, lines_q;
  logic             cfg_bad, per_end, vline_last, hbl_end, last_line, last_word, dok;

  assign t_len     = W_T'(ls_q) + W_T'(HB);
  assign per_end   = (cyc == t_len - W_T'(1));
  assign hbl_end   = (cyc == W_T'(HB - 1));
  assign last_line = (lcnt == lines_q - W_CNT'(1));
  assign last_word = (scnt[W_CNT-1:2] == ls_q[W_CNT-1:2] - W_W'(1));
  assign cfg_bad   = (line_samples_i[W_CNT-1:2] == '0) || (lines_i == '0);

  // lcnt counts line periods in the vertical phases and the active line in
  // ACTIVE/HBL; this picks the terminal value for the current phase.
  always_comb begin
    vline_last = 1'b0;
    case (state)
      S_VSYNC: vline_last = (lcnt == W_CNT'(VS_LINES - 1));
      S_VBP:   vline_last = (lcnt == W_CNT'(VBP_LINES - 1));
      S_VFP:   vline_last = (lcnt == W_CNT'(VFP_LINES - 1));
      default: vline_last = 1'b0;
    endcase
  end

`ifdef CAM_TX_DOK_GAP_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk) begin
    if (!rstn) lfsr <= LFSR_SEED;
    else       lfsr <= lfsr_next(lfsr);
  end
  assign dok = !((state == S_ACTIVE) && (lfsr[2:0] == 3'd0));
`else
  assign dok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cyc       <= '0;
      lcnt      <= '0;
      scnt      <= '0;
      ls_q      <= '0;
      lines_q   <= '0;
      cfg_err_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start_i) begin
          if (cfg_bad) cfg_err_o <= 1'b1;
          else begin
            ls_q      <= line_samples_i & ~W_CNT'(3);
            lines_q   <= lines_i;
            cfg_err_o <= 1'b0;
            cyc       <= '0;
            lcnt      <= '0;
            state     <= S_VSYNC;
          end
        end
        S_VSYNC, S_VBP, S_VFP: begin
          if (per_end) begin
            cyc <= '0;
            if (vline_last) begin
              lcnt <= '0;
              scnt <= '0;
              if (state == S_VSYNC)    state <= S_VBP;
              else if (state == S_VBP) state <= S_ACTIVE;
              else                     state <= continuous_i ? S_VSYNC : S_IDLE;
            end else begin
              lcnt <= lcnt + W_CNT'(1);
            end
          end else begin
            cyc <= cyc + W_T'(1);
          end
        end
        S_ACTIVE: if (dok) begin
          if (scnt == ls_q - W_CNT'(1)) begin
            scnt  <= '0;
            cyc   <= '0;
            state <= S_HBL;
          end else begin
            scnt <= scnt + W_CNT'(1);
          end
        end
        S_HBL: begin
          if (hbl_end) begin
            cyc <= '0;
            if (last_line) begin
              lcnt  <= '0;
              state <= S_VFP;
            end else begin
              lcnt  <= lcnt + W_CNT'(1);
              state <= S_ACTIVE;
            end
          end else begin
            cyc <= cyc + W_T'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // First word of a line is read two cycles before ACTIVE and loaded on the
  // last blanking cycle; inside a line, word n+1 is read at phase 2 of word n
  // and loaded at phase 3. Gaps stall both.
  always_comb begin
    ctl_o       = '0;
    ctl_o.href  = (state == S_ACTIVE);
    ctl_o.phase = scnt[1:0];
    ctl_o.fetch = ((state == S_VBP) && vline_last && (cyc == t_len - W_T'(2)))
                | ((state == S_HBL) && !last_line && (cyc == W_T'(HB - 2)))
                | ((state == S_ACTIVE) && dok && (scnt[1:0] == 2'd2) && !last_word);
    ctl_o.load  = ((state == S_VBP) && vline_last && per_end)
                | ((state == S_HBL) && !last_line && hbl_end)
                | ((state == S_ACTIVE) && dok && (scnt[1:0] == 2'd3));
  end

  assign accept_o     = (state == S_IDLE) && start_i && !cfg_bad;
  assign vsync_o      = (state == S_VSYNC);
  assign dok_o        = dok;
  assign busy_o       = (state != S_IDLE);
  assign frame_done_o = (state == S_VFP) && vline_last && per_end;

endmodule

// File: rtl/cam_tx.sv
// cam_tx: DVP-style camera transmitter replaying a packed frame buffer.
//   clk, rstn        : clock, synchronous active-low reset
//   start_i          : frame start pulse (ignored while busy)
//   continuous_i     : restart automatically after the front porch
//   line_samples_i, lines_i, base_addr_i : frame config, latched on start
//   rd_en_o, rd_addr_o, rd_data_i : frame-buffer read port (1-cycle latency)
//   cam_vsync_o, cam_href_o, cam_data_o, cam_data_ok_o : camera interface
//   busy_o, frame_done_o, cfg_err_o : status
// Optional: define CAM_TX_DOK_GAP_EN for pseudo-random data_ok gaps.
module cam_tx
  import cam_tx_pkg::*;
#(
  parameter int W_SAMP    = 8,
  parameter int W_CNT     = 12,
  parameter int W_ADDR    = 14,
  parameter int VS_LINES  = 2,
  parameter int VBP_LINES = 2,
  parameter int VFP_LINES = 1,
  parameter int HBLANK    = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start_i,
  input  logic                continuous_i,
  input  logic [W_CNT-1:0]    line_samples_i,
  input  logic [W_CNT-1:0]    lines_i,
  input  logic [W_ADDR-1:0]   base_addr_i,
  output logic                rd_en_o,
  output logic [W_ADDR-1:0]   rd_addr_o,
  input  logic [4*W_SAMP-1:0] rd_data_i,
  output logic                cam_vsync_o,
  output logic                cam_href_o,
  output logic [W_SAMP-1:0]   cam_data_o,
  output logic                cam_data_ok_o,
  output logic                busy_o,
  output logic                frame_done_o,
  output logic                cfg_err_o
);
  tx_ctl_t                ctl;
  logic                   accept, vsync;
  logic [W_ADDR-1:0]      base_q, addr_q;
  logic [3:0][W_SAMP-1:0] cur_w, nxt_w;
  logic                   rd_vld;
  logic [W_SAMP-1:0]      data_q;

  cam_tx_timing #(
    .W_CNT    (W_CNT),
    .VS_LINES (VS_LINES),
    .VBP_LINES(VBP_LINES),
    .VFP_LINES(VFP_LINES),
    .HBLANK   (HBLANK)
  ) u_timing (
    .clk           (clk),
    .rstn          (rstn),
    .start_i       (start_i),
    .continuous_i  (continuous_i),
    .line_samples_i(line_samples_i),
    .lines_i       (lines_i),
    .accept_o      (accept),
    .ctl_o         (ctl),
    .vsync_o       (vsync),
    .dok_o         (cam_data_ok_o),
    .busy_o        (busy_o),
    .frame_done_o  (frame_done_o),
    .cfg_err_o     (cfg_err_o)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      base_q <= '0;
      addr_q <= '0;
      rd_vld <= 1'b0;
      cur_w  <= '0;
      nxt_w  <= '0;
      data_q <= '0;
    end else begin
      if (accept) base_q <= base_addr_i;
      // The word index restarts every frame: vsync precedes any read.
      if (vsync)          addr_q <= base_q;
      else if (ctl.fetch) addr_q <= addr_q + W_ADDR'(1);
      rd_vld <= ctl.fetch;
      // nxt_w catches read data that arrives while the load is stalled by a gap.
      if (rd_vld)   nxt_w <= rd_data_i;
      if (ctl.load) cur_w <= rd_vld ? rd_data_i : nxt_w;
      data_q <= cam_data_o;
    end
  end

  assign rd_en_o     = ctl.fetch;
  assign rd_addr_o   = addr_q;
  assign cam_vsync_o = vsync;
  assign cam_href_o  = ctl.href;
  assign cam_data_o  = ctl.href ? cur_w[ctl.phase] : data_q;

endmodule
